// File: rtl/controle_multiciclo.sv
// Multicycle MIPS main control: a Moore FSM that sequences fetch, decode, execute, memory and
// writeback, and drives every datapath enable and mux select from the current state.
module controle_multiciclo #(
   parameter bit ILLEGAL_HALT = 1'b0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] opcode,
   input  logic       mem_ready,
   output logic       PCWrite,
   output logic       PCWriteCond,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       MemtoReg,
   output logic       RegDst,
   output logic       RegWrite,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUOp,
   output logic [1:0] PCSource,
   output logic [3:0] state,
   output logic       illegal
);

   typedef enum logic [3:0] {
      IDLE     = 4'd0,
      FETCH    = 4'd1,
      DECODE   = 4'd2,
      MEMADR   = 4'd3,
      MEMREAD  = 4'd4,
      MEMWB    = 4'd5,
      MEMWRITE = 4'd6,
      EXEC     = 4'd7,
      ALUWB    = 4'd8,
      BRANCH   = 4'd9,
      ADDIEX   = 4'd10,
      ADDIWB   = 4'd11,
      JUMP     = 4'd12,
      HALT     = 4'd15
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   state_t state_r;
   state_t next_s;

   function automatic logic op_supported(input logic [5:0] op);
      logic ok;
      case (op)
         OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: ok = 1'b1;
         default:                                       ok = 1'b0;
      endcase
      return ok;
   endfunction

   // state register; reset abandons any instruction in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_s;
      end
   end

   // next-state decode; encodings outside the enum fall back to FETCH
   always_comb begin
      next_s = state_r;
      case (state_r)
         IDLE:     next_s = FETCH;
         FETCH:    if (mem_ready) next_s = DECODE; else next_s = FETCH;
         DECODE: begin
            case (opcode)
               OP_RTYPE:     next_s = EXEC;
               OP_LW, OP_SW: next_s = MEMADR;
               OP_BEQ:       next_s = BRANCH;
               OP_ADDI:      next_s = ADDIEX;
               OP_J:         next_s = JUMP;
               default:      next_s = ILLEGAL_HALT ? HALT : FETCH;
            endcase
         end
         MEMADR: begin
            if (opcode == OP_LW)      next_s = MEMREAD;
            else if (opcode == OP_SW) next_s = MEMWRITE;
            else                      next_s = FETCH;
         end
         MEMREAD:  if (mem_ready) next_s = MEMWB; else next_s = MEMREAD;
         MEMWRITE: if (mem_ready) next_s = FETCH; else next_s = MEMWRITE;
         EXEC:     next_s = ALUWB;
         ADDIEX:   next_s = ADDIWB;
         MEMWB, ALUWB, ADDIWB, BRANCH, JUMP: next_s = FETCH;
         HALT:     next_s = HALT;
         default:  next_s = FETCH;
      endcase
   end

   // Moore output decode; FETCH gates PC/IR writes on mem_ready so a stall cannot double-increment
   always_comb begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      MemtoReg    = 1'b0;
      RegDst      = 1'b0;
      RegWrite    = 1'b0;
      ALUSrcA     = 1'b0;
      ALUSrcB     = 2'b00;
      ALUOp       = 2'b00;
      PCSource    = 2'b00;
      case (state_r)
         FETCH: begin
            MemRead = 1'b1;
            ALUSrcB = 2'b01;
            if (mem_ready) begin
               IRWrite = 1'b1;
               PCWrite = 1'b1;
            end else begin
               IRWrite = 1'b0;
               PCWrite = 1'b0;
            end
         end
         DECODE:   ALUSrcB = 2'b11;
         MEMADR, ADDIEX: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
         end
         MEMREAD: begin
            MemRead = 1'b1;
            IorD    = 1'b1;
         end
         MEMWRITE: begin
            MemWrite = 1'b1;
            IorD     = 1'b1;
         end
         MEMWB: begin
            RegWrite = 1'b1;
            MemtoReg = 1'b1;
         end
         ALUWB: begin
            RegWrite = 1'b1;
            RegDst   = 1'b1;
         end
         ADDIWB:   RegWrite = 1'b1;
         EXEC: begin
            ALUSrcA = 1'b1;
            ALUOp   = 2'b10;
         end
         BRANCH: begin
            ALUSrcA     = 1'b1;
            ALUOp       = 2'b01;
            PCWriteCond = 1'b1;
            PCSource    = 2'b01;
         end
         JUMP: begin
            PCWrite  = 1'b1;
            PCSource = 2'b10;
         end
         default: PCWrite = 1'b0;
      endcase
   end

   assign state   = state_r;
   assign illegal = (state_r == DECODE) && !op_supported(opcode);

endmodule

// File: tb/tb_controle_multiciclo.sv
// Directed bench for controle_multiciclo: walks each instruction class through the FSM and
// compares state, the packed control word and illegal against hand-computed values.
module tb_controle_multiciclo;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       rst_n_h;
   logic [5:0] opcode;
   logic [5:0] opcode_h;
   logic       mem_ready;

   logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
   logic       MemtoReg, RegDst, RegWrite, ALUSrcA, illegal;
   logic [1:0] ALUSrcB, ALUOp, PCSource;
   logic [3:0] state;

   logic       h_PCWrite, h_PCWriteCond, h_IorD, h_MemRead, h_MemWrite, h_IRWrite;
   logic       h_MemtoReg, h_RegDst, h_RegWrite, h_ALUSrcA, h_illegal;
   logic [1:0] h_ALUSrcB, h_ALUOp, h_PCSource;
   logic [3:0] h_state;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   controle_multiciclo #(.ILLEGAL_HALT(1'b0)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
      .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
      .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
      .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
      .PCSource(PCSource), .state(state), .illegal(illegal)
   );

   controle_multiciclo #(.ILLEGAL_HALT(1'b1)) dut_h (
      .clk(clk), .rst_n(rst_n_h), .opcode(opcode_h), .mem_ready(mem_ready),
      .PCWrite(h_PCWrite), .PCWriteCond(h_PCWriteCond), .IorD(h_IorD), .MemRead(h_MemRead),
      .MemWrite(h_MemWrite), .IRWrite(h_IRWrite), .MemtoReg(h_MemtoReg), .RegDst(h_RegDst),
      .RegWrite(h_RegWrite), .ALUSrcA(h_ALUSrcA), .ALUSrcB(h_ALUSrcB), .ALUOp(h_ALUOp),
      .PCSource(h_PCSource), .state(h_state), .illegal(h_illegal)
   );

   // {state, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
   //  RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, illegal}
   logic [20:0] mv, hv;
   assign mv = {state, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, illegal};
   assign hv = {h_state, h_PCWrite, h_PCWriteCond, h_IorD, h_MemRead, h_MemWrite, h_IRWrite,
                h_MemtoReg, h_RegDst, h_RegWrite, h_ALUSrcA, h_ALUSrcB, h_ALUOp, h_PCSource,
                h_illegal};

   localparam logic [15:0] O_ZERO   = 16'h0000;
   localparam logic [15:0] O_FETCH  = 16'h9410;
   localparam logic [15:0] O_FSTALL = 16'h1010;
   localparam logic [15:0] O_DECODE = 16'h0030;
   localparam logic [15:0] O_ADR    = 16'h0060;
   localparam logic [15:0] O_MRD    = 16'h3000;
   localparam logic [15:0] O_MWR    = 16'h2800;
   localparam logic [15:0] O_MWB    = 16'h0280;
   localparam logic [15:0] O_ALUWB  = 16'h0180;
   localparam logic [15:0] O_ADDIWB = 16'h0080;
   localparam logic [15:0] O_EXEC   = 16'h0048;
   localparam logic [15:0] O_BRANCH = 16'h4045;
   localparam logic [15:0] O_JUMP   = 16'h8002;

   task automatic chk(input string tag, input logic [20:0] obs, input logic [20:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed state=%0d ctrl=%h illegal=%b, expected state=%0d ctrl=%h illegal=%b",
                  tag, obs[20:17], obs[16:1], obs[0], exp[20:17], exp[16:1], exp[0]);
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      rst_n     = 1'b0;
      rst_n_h   = 1'b0;
      mem_ready = 1'b1;
      opcode    = 6'b000000;
      opcode_h  = 6'b111111;
      @(negedge clk);
      chk("idle", mv, {4'd0, O_ZERO, 1'b0});
      chk("idle_h", hv, {4'd0, O_ZERO, 1'b0});
      rst_n = 1'b1;

      // R-type
      tick(); chk("r_fetch",  mv, {4'd1, O_FETCH, 1'b0});
      tick(); chk("r_decode", mv, {4'd2, O_DECODE, 1'b0});
      tick(); chk("r_exec",   mv, {4'd7, O_EXEC, 1'b0});
      tick(); chk("r_aluwb",  mv, {4'd8, O_ALUWB, 1'b0});
      tick(); chk("r_fetch2", mv, {4'd1, O_FETCH, 1'b0});

      // FETCH stall, then LW with a 3-edge MEMREAD stall
      opcode    = 6'b100011;
      mem_ready = 1'b0;
      tick(); chk("fetch_stall", mv, {4'd1, O_FSTALL, 1'b0});
      mem_ready = 1'b1;
      #1 chk("fetch_resume", mv, {4'd1, O_FETCH, 1'b0});
      tick(); chk("lw_decode", mv, {4'd2, O_DECODE, 1'b0});
      tick(); chk("lw_memadr", mv, {4'd3, O_ADR, 1'b0});
      tick(); chk("lw_memrd1", mv, {4'd4, O_MRD, 1'b0});
      mem_ready = 1'b0;
      tick(); chk("lw_memrd2", mv, {4'd4, O_MRD, 1'b0});
      tick(); chk("lw_memrd3", mv, {4'd4, O_MRD, 1'b0});
      tick(); chk("lw_memrd4", mv, {4'd4, O_MRD, 1'b0});
      mem_ready = 1'b1;
      tick(); chk("lw_memwb", mv, {4'd5, O_MWB, 1'b0});
      tick(); chk("lw_fetch", mv, {4'd1, O_FETCH, 1'b0});

      // BEQ
      opcode = 6'b000100;
      tick(); chk("beq_decode", mv, {4'd2, O_DECODE, 1'b0});
      tick(); chk("beq_branch", mv, {4'd9, O_BRANCH, 1'b0});
      tick(); chk("beq_fetch",  mv, {4'd1, O_FETCH, 1'b0});

      // J
      opcode = 6'b000010;
      tick(); chk("j_decode", mv, {4'd2, O_DECODE, 1'b0});
      tick(); chk("j_jump",   mv, {4'd12, O_JUMP, 1'b0});
      tick(); chk("j_fetch",  mv, {4'd1, O_FETCH, 1'b0});

      // ADDI
      opcode = 6'b001000;
      tick(); chk("addi_decode", mv, {4'd2, O_DECODE, 1'b0});
      tick(); chk("addi_ex",     mv, {4'd10, O_ADR, 1'b0});
      tick(); chk("addi_wb",     mv, {4'd11, O_ADDIWB, 1'b0});
      tick(); chk("addi_fetch",  mv, {4'd1, O_FETCH, 1'b0});

      // unsupported opcode, ILLEGAL_HALT=0
      opcode = 6'b111111;
      tick(); chk("ill_decode", mv, {4'd2, O_DECODE, 1'b1});
      tick(); chk("ill_fetch",  mv, {4'd1, O_FETCH, 1'b0});

      // SW interrupted by reset while in MEMWRITE
      opcode = 6'b101011;
      tick(); chk("sw_decode", mv, {4'd2, O_DECODE, 1'b0});
      tick(); chk("sw_memadr", mv, {4'd3, O_ADR, 1'b0});
      tick(); chk("sw_memwr",  mv, {4'd6, O_MWR, 1'b0});
      #1 rst_n = 1'b0;
      #1 chk("sw_rst_now", mv, {4'd0, O_ZERO, 1'b0});
      tick(); chk("sw_rst_hold", mv, {4'd0, O_ZERO, 1'b0});
      rst_n = 1'b1;
      tick(); chk("sw_rst_fetch", mv, {4'd1, O_FETCH, 1'b0});

      // unsupported opcode, ILLEGAL_HALT=1
      rst_n_h = 1'b1;
      tick(); chk("halt_fetch",  hv, {4'd1, O_FETCH, 1'b0});
      tick(); chk("halt_decode", hv, {4'd2, O_DECODE, 1'b1});
      tick(); chk("halt_1",      hv, {4'd15, O_ZERO, 1'b0});
      tick(); chk("halt_2",      hv, {4'd15, O_ZERO, 1'b0});
      tick(); chk("halt_3",      hv, {4'd15, O_ZERO, 1'b0});
      rst_n_h = 1'b0;
      #1 chk("halt_reset", hv, {4'd0, O_ZERO, 1'b0});

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
